sr_latch_driver: RTL
====================

Name: sr_latch_driver

Overview:
- Synchronous controller that drives the En/S/R inputs of the team's gated SR latch from single-cycle set/clear requests, and reads the latch's Q back to confirm the write.
- Guarantees S and R are never asserted together.
- Holds S/R stable around the En pulse with a programmable setup/hold margin.
- Reports completion (Done) or failure (Err) to the requesting logic.
- Sits between clocked control logic and the asynchronous gate-level latch.

Parameters:
- PULSE_CYCLES, 2, clock cycles En is held high; legal range ≥1.
- SETTLE_CYCLES, 1, clock cycles S/R are held before En rises and after En falls; legal range ≥1.
- CNT_W, 4, width of the internal phase counter; must hold max(PULSE_CYCLES, SETTLE_CYCLES).

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- SetReq  input  1  request to set the latch (Q→1); sampled only in IDLE.
- ClrReq  input  1  request to clear the latch (Q→0); sampled only in IDLE.
- Q  input  1  latch true output, fed back for verification.
- En  output  1  latch enable, registered.
- S  output  1  latch set input, registered.
- R  output  1  latch reset input, registered.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse: operation completed and Q matched the target.
- Err  output  1  one-cycle pulse: request conflict or Q mismatch.

Behaviour:
- Reset (async, Rst=1):
  - State goes to IDLE immediately.
  - En=S=R=Busy=Done=Err=0, counter=0, target=0.
  - Reset mid-operation drops En/S/R at once, with no clock edge required.
  - The latch keeps whatever value it had; the driver makes no assumption about Q after reset.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK.
- IDLE:
  - SetReq=1, ClrReq=0: target=1, S=1, Busy=1, go to SETUP.
  - ClrReq=1, SetReq=0: target=0, R=1, Busy=1, go to SETUP.
  - Both high: no latch activity, Err=1 for one cycle, stay in IDLE.
  - Neither high: stay in IDLE.
- SETUP:
  - Counts SETTLE_CYCLES cycles with S/R held and En=0.
  - On the last cycle, set En=1 and go to PULSE.
- PULSE:
  - En=1 for exactly PULSE_CYCLES cycles.
  - Then En=0 and go to HOLD, with S/R still held.
- HOLD:
  - S/R held for SETTLE_CYCLES cycles with En=0.
  - Then S=R=0 and go to CHECK.
- CHECK (one cycle):
  - Compare Q with target at the exit edge.
  - Match: Done=1. Mismatch: Err=1.
  - Busy=0; go to IDLE.
- Latency:
  - Request sampled at edge k.
  - Done/Err rise at edge k+2*SETTLE_CYCLES+PULSE_CYCLES+1 (k+5 with defaults).
  - Busy falls on that same edge.
- Throughput:
  - A request present during the Done/Err cycle is accepted (back-to-back, one idle cycle between operations).
  - Requests arriving while Busy=1 are ignored and not queued.
- Invariant: S&R is never 1; En=1 only when exactly one of S/R is 1.
- Q is treated as asynchronous and is sampled only in CHECK. HOLD provides the settle time; SETTLE_CYCLES × clock period must exceed the latch's worst-case propagation (4 gate delays, 8 ns).
- The counter reloads on every state entry; no wrap-around is possible within legal parameters.

Decomposition:
- Package sr_drv_pkg:
  - State encoding constants IDLE=0, SETUP=1, PULSE=2, HOLD=3, CHECK=4 (3 bits).
  - Default timing constants.
- Sub-module sr_drv_timer:
  - Loadable down-counter of width CNT_W with a terminal-count flag.
  - Instantiated once and reloaded by the FSM on each phase entry.

Test Plan:
- Rst pulse mid-PULSE (En=1, S=1) → En, S, Busy drop to 0 asynchronously before the next Clk edge; FSM is in IDLE afterwards.
- SetReq one cycle at edge 10, defaults, latch model Q follows → S=1 edges 10–13, En=1 edges 11–12, Done=1 at edge 15, Q=1, Err never asserts.
- ClrReq at edge 20 with Q=1 → R=1 edges 20–23, En=1 edges 21–22, Done at 25, Q=0, S stays 0 throughout.
- SetReq=ClrReq=1 in IDLE → Err=1 for one cycle, En/S/R stay 0, Busy stays 0.
- Q tied to 0 (stuck latch), SetReq → full sequence runs, Err=1 at edge k+5, Done stays 0.
- SetReq held high continuously, PULSE_CYCLES=3, SETTLE_CYCLES=2 → one operation every 9 cycles, Done at k+8; assertion check that S&R is never 1 and En never rises without S or R.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Shared types and default timing for the gated SR latch driver.
// State encoding is fixed so it can be probed and decoded on a bench or logic analyser.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_e;

  localparam int unsigned DEF_PULSE_CYCLES  = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 1;
  localparam int unsigned DEF_CNT_W         = 4;

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter used to time each driver phase.
// tc is high while the count is zero; a load takes priority over counting.
module sr_drv_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives En/S/R of a gated SR latch with setup/pulse/hold phasing and verifies Q afterwards.
// All outputs are registered; Q is only looked at in CHECK, after HOLD has let the latch settle.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic Clk,
  input  logic Rst,
  input  logic SetReq,
  input  logic ClrReq,
  input  logic Q,
  output logic En,
  output logic S,
  output logic R,
  output logic Busy,
  output logic Done,
  output logic Err
);

  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  state_e state_q, state_d;
  logic   en_q, en_d;
  logic   s_q, s_d;
  logic   r_q, r_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic   target_q, target_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;

  sr_drv_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (Clk),
    .rst      (Rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    s_d      = s_q;
    r_d      = r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    target_d = target_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      IDLE: begin
        if (SetReq && ClrReq) begin
          err_d = 1'b1;
        end else if (SetReq || ClrReq) begin
          target_d = SetReq;
          s_d      = SetReq;
          r_d      = ClrReq;
          busy_d   = 1'b1;
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      SETUP: begin
        if (tmr_tc) begin
          en_d     = 1'b1;
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      PULSE: begin
        if (tmr_tc) begin
          en_d     = 1'b0;
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      HOLD: begin
        if (tmr_tc) begin
          s_d      = 1'b0;
          r_d      = 1'b0;
          state_d  = CHECK;
          tmr_load = 1'b1;
        end
      end
      CHECK: begin
        done_d  = (Q == target_q);
        err_d   = (Q != target_q);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        en_d    = 1'b0;
        s_d     = 1'b0;
        r_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Asynchronous reset drops En/S/R immediately; the latch retains its old value.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      target_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      s_q      <= s_d;
      r_q      <= r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      target_q <= target_d;
    end
  end

  assign En   = en_q;
  assign S    = s_q;
  assign R    = r_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Err  = err_q;

endmodule
